alu_issue_ctrl: RTL and testbench

Sequential front-end that owns the initiator side of the 4-bit-control ALU interface. It accepts one operation per valid/ready request (ALUOp, funct, shamt, two 32-bit operands) and decodes it into the shared ALU control code. It then drives registered operands into the combinational ALU, captures the result and returns it on a valid/ready response channel with a zero flag. It sits between the datapath issue logic and the ALU, replacing ad-hoc combinational control decode.

---
 rtl/alu_issue_ctrl.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//
// Purpose:
//   Sequential front-end for the 4-bit-control ALU. It accepts one operation
//   per valid/ready request, decodes ALUOp/funct into the ALU control code and
//   registers the operands that drive the combinational ALU. After one execute
//   cycle it captures the ALU result. The result is then returned on a
//   valid/ready response channel together with a zero flag and an
//   illegal-decode flag.
//
// Ports:
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   req_valid    in   1   request present
//   req_ready    out  1   block can accept a request (IDLE only)
//   req_aluop    in   2   00=ADD, 01=SUB, 10=decode funct, 11=OR
//   req_funct    in   6   R-type funct field
//   req_shamt    in   5   shift amount
//   req_a        in  32   operand rs
//   req_b        in  32   operand rt / immediate
//   alu_ctrl     out  4   control code to the ALU
//   alu_a        out 32   ALU operand A
//   alu_b        out 32   ALU operand B
//   alu_result   in  32   combinational ALU output
//   rsp_valid    out  1   response present (RESP only)
//   rsp_ready    in   1   consumer takes the response
//   rsp_result   out 32   captured result
//   rsp_zero     out  1   rsp_result == 0
//   rsp_illegal  out  1   funct was not decodable
//   rsp_ovf      out  1   signed overflow of ADD/SUB (only with ALU_ISSUE_OVF_EN)
//
// Configuration:
//   ALU_ISSUE_OVF_EN  when defined, adds the rsp_ovf output and its overflow
//                     detection logic. When undefined, neither exists.
// ---------------------------------------------------------------------------
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_aluop,
    input  logic [5:0]  req_funct,
    input  logic [4:0]  req_shamt,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [3:0]  alu_ctrl,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_illegal
`ifdef ALU_ISSUE_OVF_EN
    ,
    output logic        rsp_ovf
`endif
);

    // ALU control codes shared with the ALU
    localparam logic [3:0] CTRL_AND = 4'h0;
    localparam logic [3:0] CTRL_OR  = 4'h1;
    localparam logic [3:0] CTRL_ADD = 4'h2;
    localparam logic [3:0] CTRL_SLL = 4'h3;
    localparam logic [3:0] CTRL_SRL = 4'h4;
    localparam logic [3:0] CTRL_SUB = 4'h6;
    localparam logic [3:0] CTRL_SLT = 4'h7;
    localparam logic [3:0] CTRL_NOR = 4'hC;
    localparam logic [3:0] CTRL_ILL = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;

    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        illegal_q, illegal_d;
    logic [31:0] result_q, result_d;
    logic        zero_q, zero_d;
    logic        rsp_illegal_q, rsp_illegal_d;

    // Combinational decode of the incoming request
    logic [3:0]  dec_ctrl;
    logic        dec_illegal;
    logic        dec_shift;
    logic [31:0] dec_a;
    logic [31:0] dec_b;

    // Result as it will be captured at the end of EXEC
    logic [31:0] exec_result;

`ifdef ALU_ISSUE_OVF_EN
    logic        dec_add_signed;
    logic        dec_sub_signed;
    logic        add_signed_q, add_signed_d;
    logic        sub_signed_q, sub_signed_d;
    logic        ovf_q, ovf_d;
    logic        exec_ovf;
`endif

    // Decode ALUOp/funct into the ALU control code. Only ALUOp=10 consults
    // funct and can therefore be illegal. Shifts take the shifted value from
    // rt and the amount from shamt, so their operands are swapped relative to
    // every other operation.
    always_comb begin
        dec_ctrl    = CTRL_ILL;
        dec_illegal = 1'b0;
`ifdef ALU_ISSUE_OVF_EN
        dec_add_signed = 1'b0;
        dec_sub_signed = 1'b0;
`endif
        case (req_aluop)
            2'b00: begin
                dec_ctrl = CTRL_ADD;
`ifdef ALU_ISSUE_OVF_EN
                dec_add_signed = 1'b1;
`endif
            end
            2'b01: begin
                dec_ctrl = CTRL_SUB;
`ifdef ALU_ISSUE_OVF_EN
                dec_sub_signed = 1'b1;
`endif
            end
            2'b11: begin
                dec_ctrl = CTRL_OR;
            end
            default: begin
                case (req_funct)
                    6'h20: begin
                        dec_ctrl = CTRL_ADD;
`ifdef ALU_ISSUE_OVF_EN
                        dec_add_signed = 1'b1;
`endif
                    end
                    6'h21: dec_ctrl = CTRL_ADD;
                    6'h22: begin
                        dec_ctrl = CTRL_SUB;
`ifdef ALU_ISSUE_OVF_EN
                        dec_sub_signed = 1'b1;
`endif
                    end
                    6'h23: dec_ctrl = CTRL_SUB;
                    6'h24: dec_ctrl = CTRL_AND;
                    6'h25: dec_ctrl = CTRL_OR;
                    6'h27: dec_ctrl = CTRL_NOR;
                    6'h2A: dec_ctrl = CTRL_SLT;
                    6'h00: dec_ctrl = CTRL_SLL;
                    6'h02: dec_ctrl = CTRL_SRL;
                    default: begin
                        dec_ctrl    = CTRL_ILL;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
        endcase

        dec_shift = (dec_ctrl == CTRL_SLL) || (dec_ctrl == CTRL_SRL);
        dec_a     = dec_shift ? req_b : req_a;
        dec_b     = dec_shift ? {27'b0, req_shamt} : req_b;
    end

    // An illegal decode drives 4'hF into the ALU, which should already
    // return 0. The result is forced to 0 anyway so the response never
    // depends on that ALU behaviour.
    always_comb begin
        exec_result = illegal_q ? 32'h0 : alu_result;
    end

`ifdef ALU_ISSUE_OVF_EN
    // Signed overflow is judged from sign bits only. ADD overflows when both
    // operands share a sign the result lacks. SUB overflows when the operands
    // differ in sign and the result's sign differs from A.
    always_comb begin
        exec_ovf = (add_signed_q && (a_q[31] == b_q[31]) && (alu_result[31] != a_q[31])) ||
                   (sub_signed_q && (a_q[31] != b_q[31]) && (alu_result[31] != a_q[31]));
    end
`endif

    // Next-state and output logic. Operand/control registers only load on
    // acceptance in IDLE, so they hold their values through EXEC and beyond.
    // The response fields only load at the end of EXEC, so they stay stable
    // for as long as RESP waits on rsp_ready.
    always_comb begin
        state_d       = state_q;
        ctrl_d        = ctrl_q;
        a_d           = a_q;
        b_d           = b_q;
        illegal_d     = illegal_q;
        result_d      = result_q;
        zero_d        = zero_q;
        rsp_illegal_d = rsp_illegal_q;
`ifdef ALU_ISSUE_OVF_EN
        add_signed_d  = add_signed_q;
        sub_signed_d  = sub_signed_q;
        ovf_d         = ovf_q;
`endif
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    ctrl_d    = dec_ctrl;
                    a_d       = dec_a;
                    b_d       = dec_b;
                    illegal_d = dec_illegal;
`ifdef ALU_ISSUE_OVF_EN
                    add_signed_d = dec_add_signed;
                    sub_signed_d = dec_sub_signed;
`endif
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d      = exec_result;
                zero_d        = (exec_result == 32'h0);
                rsp_illegal_d = illegal_q;
`ifdef ALU_ISSUE_OVF_EN
                ovf_d         = exec_ovf;
`endif
                state_d       = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and data registers. Reset aborts whatever is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ctrl_q        <= CTRL_ILL;
            a_q           <= 32'h0;
            b_q           <= 32'h0;
            illegal_q     <= 1'b0;
            result_q      <= 32'h0;
            zero_q        <= 1'b0;
            rsp_illegal_q <= 1'b0;
`ifdef ALU_ISSUE_OVF_EN
            add_signed_q  <= 1'b0;
            sub_signed_q  <= 1'b0;
            ovf_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            ctrl_q        <= ctrl_d;
            a_q           <= a_d;
            b_q           <= b_d;
            illegal_q     <= illegal_d;
            result_q      <= result_d;
            zero_q        <= zero_d;
            rsp_illegal_q <= rsp_illegal_d;
`ifdef ALU_ISSUE_OVF_EN
            add_signed_q  <= add_signed_d;
            sub_signed_q  <= sub_signed_d;
            ovf_q         <= ovf_d;
`endif
        end
    end

    assign alu_ctrl    = ctrl_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign rsp_result  = result_q;
    assign rsp_zero    = zero_q;
    assign rsp_illegal = rsp_illegal_q;
`ifdef ALU_ISSUE_OVF_EN
    assign rsp_ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
//
// Directed testbench for alu_issue_ctrl. A behavioural ALU closes the loop
// on alu_ctrl/alu_a/alu_b. Each operation is issued and its EXEC-cycle
// outputs are checked, then its response is checked against hand-computed
// values. Define ALU_ISSUE_OVF_EN to also exercise rsp_ovf.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_aluop;
    logic [5:0]  req_funct;
    logic [4:0]  req_shamt;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_illegal;
`ifdef ALU_ISSUE_OVF_EN
    logic        rsp_ovf;
`endif

    int errors = 0;
    int checks = 0;

    alu_issue_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_aluop   (req_aluop),
        .req_funct   (req_funct),
        .req_shamt   (req_shamt),
        .req_a       (req_a),
        .req_b       (req_b),
        .alu_ctrl    (alu_ctrl),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_illegal (rsp_illegal)
`ifdef ALU_ISSUE_OVF_EN
        ,
        .rsp_ovf     (rsp_ovf)
`endif
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: shifts move alu_a by alu_b[4:0], unknown codes give 0
    always_comb begin
        alu_result = 32'h0;
        case (alu_ctrl)
            4'h0: alu_result = alu_a & alu_b;
            4'h1: alu_result = alu_a | alu_b;
            4'h2: alu_result = alu_a + alu_b;
            4'h3: alu_result = alu_a << alu_b[4:0];
            4'h4: alu_result = alu_a >> alu_b[4:0];
            4'h6: alu_result = alu_a - alu_b;
            4'h7: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'h1 : 32'h0;
            4'hC: alu_result = ~(alu_a | alu_b);
            default: alu_result = 32'h0;
        endcase
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just past the rising edge
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Present one request and hold it until accepted (bounded wait). On
    // return the DUT is in EXEC and req_valid has been dropped.
    task automatic applyStimulus(input logic [1:0] aluop, input logic [5:0] funct,
                                 input logic [4:0] shamt, input logic [31:0] a,
                                 input logic [31:0] b);
        int waitCycles;
        req_aluop  = aluop;
        req_funct  = funct;
        req_shamt  = shamt;
        req_a      = a;
        req_b      = b;
        req_valid  = 1'b1;
        waitCycles = 0;
        while (!req_ready && waitCycles < 20) begin
            stepCycle();
            waitCycles++;
        end
        if (!req_ready) begin
            checkOutput("accept_timeout", {31'b0, req_ready}, 32'h1);
        end
        stepCycle();
        req_valid = 1'b0;
    endtask

    // Issue one operation, check EXEC-cycle ALU drive, then the response.
    // The response is left pending in RESP for the caller to retire.
    task automatic runOp(input string tag, input logic [1:0] aluop,
                         input logic [5:0] funct, input logic [4:0] shamt,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] expCtrl, input logic [31:0] expA,
                         input logic [31:0] expB, input logic [31:0] expResult,
                         input logic expIllegal);
        applyStimulus(aluop, funct, shamt, a, b);
        checkOutput({tag, "_exec_ctrl"}, {28'b0, alu_ctrl}, {28'b0, expCtrl});
        checkOutput({tag, "_exec_a"}, alu_a, expA);
        checkOutput({tag, "_exec_b"}, alu_b, expB);
        checkOutput({tag, "_exec_rvalid"}, {31'b0, rsp_valid}, 32'h0);
        checkOutput({tag, "_exec_qready"}, {31'b0, req_ready}, 32'h0);
        stepCycle();
        checkOutput({tag, "_rvalid"}, {31'b0, rsp_valid}, 32'h1);
        checkOutput({tag, "_result"}, rsp_result, expResult);
        checkOutput({tag, "_zero"}, {31'b0, rsp_zero}, {31'b0, (expResult == 32'h0)});
        checkOutput({tag, "_illegal"}, {31'b0, rsp_illegal}, {31'b0, expIllegal});
    endtask

    // Retire the pending response with a single rsp_ready cycle
    task automatic retire(input string tag);
        rsp_ready = 1'b1;
        stepCycle();
        rsp_ready = 1'b0;
        checkOutput({tag, "_retired"}, {31'b0, rsp_valid}, 32'h0);
        checkOutput({tag, "_idle_ready"}, {31'b0, req_ready}, 32'h1);
    endtask

    // Main directed sequence
    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_aluop = 2'b00;
        req_funct = 6'h00;
        req_shamt = 5'h0;
        req_a     = 32'h0;
        req_b     = 32'h0;

        // Reset values, then release with no request
        #12;
        checkOutput("rst_req_ready", {31'b0, req_ready}, 32'h1);
        checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        checkOutput("rst_alu_ctrl", {28'b0, alu_ctrl}, 32'hF);
        checkOutput("rst_rsp_result", rsp_result, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) stepCycle();
        checkOutput("idle_req_ready", {31'b0, req_ready}, 32'h1);
        checkOutput("idle_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        checkOutput("idle_alu_ctrl", {28'b0, alu_ctrl}, 32'hF);
        checkOutput("idle_alu_a", alu_a, 32'h0);

        // R-type ADD 5 + 7
        runOp("add", 2'b10, 6'h20, 5'd0, 32'd5, 32'd7, 4'h2, 32'd5, 32'd7, 32'd12, 1'b0);
        retire("add");

        // SUB via ALUOp=01 giving zero, response held for 5 cycles
        runOp("subz", 2'b01, 6'h3F, 5'd9, 32'h1234, 32'h1234, 4'h6, 32'h1234, 32'h1234,
              32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            checkOutput("hold_valid", {31'b0, rsp_valid}, 32'h1);
            checkOutput("hold_result", rsp_result, 32'h0);
            checkOutput("hold_zero", {31'b0, rsp_zero}, 32'h1);
        end
        retire("subz");

        // Shifts: operands come from rt and shamt
        runOp("sll", 2'b10, 6'h00, 5'd4, 32'hDEAD, 32'h1, 4'h3, 32'h1, 32'h4, 32'h10, 1'b0);
        retire("sll");
        runOp("srl", 2'b10, 6'h02, 5'd1, 32'hBEEF, 32'h8, 4'h4, 32'h8, 32'h1, 32'h4, 1'b0);
        retire("srl");

        // Illegal funct, then a legal OR decoded normally
        runOp("ill", 2'b10, 6'h3F, 5'd0, 32'd5, 32'd3, 4'hF, 32'd5, 32'd3, 32'h0, 1'b1);
        retire("ill");
        runOp("or", 2'b11, 6'h3F, 5'd0, 32'hF0, 32'h0F, 4'h1, 32'hF0, 32'h0F, 32'hFF, 1'b0);
        retire("or");

        // Remaining R-type codes
        runOp("and", 2'b10, 6'h24, 5'd0, 32'hFF00, 32'h0FF0, 4'h0, 32'hFF00, 32'h0FF0,
              32'h0F00, 1'b0);
        retire("and");
        runOp("slt", 2'b10, 6'h2A, 5'd0, 32'hFFFFFFFF, 32'h1, 4'h7, 32'hFFFFFFFF, 32'h1,
              32'h1, 1'b0);
        retire("slt");
        runOp("subu", 2'b10, 6'h23, 5'd0, 32'd10, 32'd3, 4'h6, 32'd10, 32'd3, 32'd7, 1'b0);
        retire("subu");

        // Response retired while a request waits: not accepted until IDLE
        runOp("nor", 2'b10, 6'h27, 5'd0, 32'h0, 32'h0, 4'hC, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0);
        req_aluop = 2'b00;
        req_funct = 6'h00;
        req_shamt = 5'd0;
        req_a     = 32'd2;
        req_b     = 32'd3;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        stepCycle();
        rsp_ready = 1'b0;
        checkOutput("overlap_retired", {31'b0, rsp_valid}, 32'h0);
        checkOutput("overlap_idle", {31'b0, req_ready}, 32'h1);
        checkOutput("overlap_not_taken", {28'b0, alu_ctrl}, 32'hC);
        stepCycle();
        req_valid = 1'b0;
        checkOutput("overlap_taken_ctrl", {28'b0, alu_ctrl}, 32'h2);
        checkOutput("overlap_taken_a", alu_a, 32'd2);
        stepCycle();
        checkOutput("overlap_result", rsp_result, 32'd5);
        retire("overlap");

`ifdef ALU_ISSUE_OVF_EN
        // Signed overflow only for the signed ADD/SUB variants
        runOp("ovf_add", 2'b10, 6'h20, 5'd0, 32'h7FFFFFFF, 32'h1, 4'h2, 32'h7FFFFFFF, 32'h1,
              32'h80000000, 1'b0);
        checkOutput("ovf_add_flag", {31'b0, rsp_ovf}, 32'h1);
        retire("ovf_add");
        runOp("ovf_addu", 2'b10, 6'h21, 5'd0, 32'h7FFFFFFF, 32'h1, 4'h2, 32'h7FFFFFFF, 32'h1,
              32'h80000000, 1'b0);
        checkOutput("ovf_addu_flag", {31'b0, rsp_ovf}, 32'h0);
        retire("ovf_addu");
        runOp("ovf_sub", 2'b01, 6'h00, 5'd0, 32'h80000000, 32'h1, 4'h6, 32'h80000000, 32'h1,
              32'h7FFFFFFF, 1'b0);
        checkOutput("ovf_sub_flag", {31'b0, rsp_ovf}, 32'h1);
        retire("ovf_sub");
        runOp("ovf_none", 2'b00, 6'h00, 5'd0, 32'd1, 32'd1, 4'h2, 32'd1, 32'd1, 32'd2, 1'b0);
        checkOutput("ovf_none_flag", {31'b0, rsp_ovf}, 32'h0);
        retire("ovf_none");
`endif

        // Reset during EXEC: everything returns to reset values at once
        applyStimulus(2'b10, 6'h20, 5'd0, 32'd5, 32'd7);
        checkOutput("midrst_in_exec", {28'b0, alu_ctrl}, 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_req_ready", {31'b0, req_ready}, 32'h1);
        checkOutput("midrst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        checkOutput("midrst_alu_ctrl", {28'b0, alu_ctrl}, 32'hF);
        checkOutput("midrst_alu_a", alu_a, 32'h0);
        checkOutput("midrst_alu_b", alu_b, 32'h0);
        checkOutput("midrst_rsp_result", rsp_result, 32'h0);
        checkOutput("midrst_rsp_zero", {31'b0, rsp_zero}, 32'h0);
        checkOutput("midrst_rsp_illegal", {31'b0, rsp_illegal}, 32'h0);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            stepCycle();
            checkOutput("midrst_no_rsp", {31'b0, rsp_valid}, 32'h0);
        end

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

endmodule
